// File: rtl/riscv_pkg.sv
// Shared core types: memory access sizes, load/store unit states and defaults.
package riscv_pkg;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'd0,
    MEM_HALF = 2'd1,
    MEM_WORD = 2'd2
  } mem_size_e;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_WAIT = 2'd2,
    LSU_DONE = 2'd3
  } lsu_state_e;

  localparam int LSU_TIMEOUT_CYC = 255;

  // Unknown size encodings are treated like a word so they stay aligned-checked.
  function automatic logic is_misaligned(mem_size_e size, logic [1:0] addr_lo);
    case (size)
      MEM_BYTE: return 1'b0;
      MEM_HALF: return addr_lo[0];
      default:  return addr_lo != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Word-oriented memory bus between the load/store unit (master) and memory (slave).
interface load_store_unit_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_gnt;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_gnt, bus_rvalid, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_gnt, bus_rvalid, bus_rdata
  );
endinterface

// File: rtl/load_store_unit_load_extend.sv
// Picks the addressed byte/half out of a bus word and sign- or zero-extends it.
module load_extend
  import riscv_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr,
  input  mem_size_e   size,
  input  logic        usign,
  output logic [31:0] ext
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[7:0];
    case (addr)
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      2'd3:    byte_sel = word[31:24];
      default: byte_sel = word[7:0];
    endcase
    half_sel = addr[1] ? word[31:16] : word[15:0];

    ext = word;
    case (size)
      MEM_BYTE: ext = usign ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      MEM_HALF: ext = usign ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
      default:  ext = word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: turns core memory requests into single word-bus transactions,
// handling lane steering, alignment faults and a bus timeout.
module load_store_unit
  import riscv_pkg::*;
#(
  parameter int TIMEOUT_CYC = LSU_TIMEOUT_CYC
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mem_read,
  input  logic               mem_write,
  input  mem_size_e          mem_size,
  input  logic               mem_usign_load,
  input  logic [31:0]        addr,
  input  logic [31:0]        wdata,
  output logic               lsu_stall,
  output logic               lsu_done,
  output logic [31:0]        lsu_rdata,
  output logic               misaligned,
  output logic               bus_err,
  load_store_unit_if.master  mem_bus
);

  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 1);

  lsu_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        addr_lo_q, addr_lo_d;
  mem_size_e         size_q, size_d;
  logic              usign_q, usign_d;
  logic [31:0]       word_q, word_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [31:0]       baddr_q, baddr_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       bwdata_q, bwdata_d;
  logic              done_q, done_d;
  logic              mis_q, mis_d;
  logic              err_q, err_d;

  logic [3:0]        st_be;
  logic [31:0]       st_data;
  logic              req_any, req_both, req_mis;
  logic [31:0]       ext_data;

  assign req_any  = mem_read | mem_write;
  assign req_both = mem_read & mem_write;
  assign req_mis  = is_misaligned(mem_size, addr[1:0]);

  always_comb begin
    st_be   = 4'b1111;
    st_data = wdata;
    case (mem_size)
      MEM_BYTE: begin
        st_be   = 4'b0001 << addr[1:0];
        st_data = {4{wdata[7:0]}};
      end
      MEM_HALF: begin
        st_be   = addr[1] ? 4'b1100 : 4'b0011;
        st_data = {2{wdata[15:0]}};
      end
      default: begin
        st_be   = 4'b1111;
        st_data = wdata;
      end
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_lo_d = addr_lo_q;
    size_d    = size_q;
    usign_d   = usign_q;
    word_d    = word_q;
    req_d     = req_q;
    we_d      = we_q;
    baddr_d   = baddr_q;
    be_d      = be_q;
    bwdata_d  = bwdata_q;
    done_d    = 1'b0;
    mis_d     = 1'b0;
    err_d     = 1'b0;
    lsu_stall = 1'b0;

    case (state_q)
      LSU_IDLE: begin
        lsu_stall = req_any;
        if (req_any) begin
          addr_lo_d = addr[1:0];
          size_d    = mem_size;
          usign_d   = mem_usign_load;
          word_d    = '0;
          if (req_both || req_mis) begin
            state_d = LSU_DONE;
            done_d  = 1'b1;
            mis_d   = req_mis;
            err_d   = req_both;
          end else begin
            state_d  = LSU_REQ;
            cnt_d    = '0;
            req_d    = 1'b1;
            we_d     = mem_write;
            baddr_d  = {addr[31:2], 2'b00};
            be_d     = mem_write ? st_be : 4'b1111;
            bwdata_d = mem_write ? st_data : 32'h0;
          end
        end
      end
      LSU_REQ: begin
        lsu_stall = 1'b1;
        cnt_d     = cnt_q + CNT_W'(1);
        // A grant in the last allowed cycle still counts as accepted.
        if (mem_bus.bus_gnt || cnt_q == TO_LAST) begin
          req_d    = 1'b0;
          we_d     = 1'b0;
          baddr_d  = '0;
          be_d     = '0;
          bwdata_d = '0;
          if (!mem_bus.bus_gnt) begin
            state_d = LSU_DONE;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end else if (we_q) begin
            state_d = LSU_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = LSU_WAIT;
          end
        end
      end
      LSU_WAIT: begin
        lsu_stall = 1'b1;
        cnt_d     = cnt_q + CNT_W'(1);
        if (mem_bus.bus_rvalid) begin
          word_d  = mem_bus.bus_rdata;
          state_d = LSU_DONE;
          done_d  = 1'b1;
        end else if (cnt_q == TO_LAST) begin
          word_d  = '0;
          state_d = LSU_DONE;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end
      end
      LSU_DONE: begin
        state_d = LSU_IDLE;
      end
      default: begin
        state_d = LSU_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= LSU_IDLE;
      cnt_q     <= '0;
      addr_lo_q <= '0;
      size_q    <= MEM_BYTE;
      usign_q   <= 1'b0;
      word_q    <= '0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      baddr_q   <= '0;
      be_q      <= '0;
      bwdata_q  <= '0;
      done_q    <= 1'b0;
      mis_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_lo_q <= addr_lo_d;
      size_q    <= size_d;
      usign_q   <= usign_d;
      word_q    <= word_d;
      req_q     <= req_d;
      we_q      <= we_d;
      baddr_q   <= baddr_d;
      be_q      <= be_d;
      bwdata_q  <= bwdata_d;
      done_q    <= done_d;
      mis_q     <= mis_d;
      err_q     <= err_d;
    end
  end

  load_extend u_load_extend (
    .word  (word_q),
    .addr  (addr_lo_q),
    .size  (size_q),
    .usign (usign_q),
    .ext   (ext_data)
  );

  assign mem_bus.bus_req   = req_q;
  assign mem_bus.bus_we    = we_q;
  assign mem_bus.bus_addr  = baddr_q;
  assign mem_bus.bus_be    = be_q;
  assign mem_bus.bus_wdata = bwdata_q;

  assign lsu_done   = done_q;
  assign misaligned = mis_q;
  assign bus_err    = err_q;
  assign lsu_rdata  = done_q ? ext_data : 32'h0;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: stores, loads, alignment faults, timeout, reset mid-access.
module tb_load_store_unit;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read, mem_write, mem_usign_load;
  mem_size_e   mem_size;
  logic [31:0] addr, wdata;
  logic        lsu_stall, lsu_done, misaligned, bus_err;
  logic [31:0] lsu_rdata;
  int          passCount = 0;
  int          totalCount = 0;
  logic        reqSeen;

  load_store_unit_if bus ();

  load_store_unit #(.TIMEOUT_CYC(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_size       (mem_size),
    .mem_usign_load (mem_usign_load),
    .addr           (addr),
    .wdata          (wdata),
    .lsu_stall      (lsu_stall),
    .lsu_done       (lsu_done),
    .lsu_rdata      (lsu_rdata),
    .misaligned     (misaligned),
    .bus_err        (bus_err),
    .mem_bus        (bus.master)
  );

  always #5 clk = ~clk;

  // Advance to the next falling edge; inputs change there, outputs settle 1ns later.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic rd, input logic wr, input mem_size_e sz,
                               input logic us, input logic [31:0] a, input logic [31:0] wd);
    step();
    mem_read       = rd;
    mem_write      = wr;
    mem_size       = sz;
    mem_usign_load = us;
    addr           = a;
    wdata          = wd;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    totalCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
  endtask

  task automatic idleInputs();
    mem_read  = 1'b0;
    mem_write = 1'b0;
  endtask

  task automatic checkQuiet(input string tag);
    checkOutput({tag, "_done"},  32'(lsu_done), 32'h0);
    checkOutput({tag, "_stall"}, 32'(lsu_stall), 32'h0);
    checkOutput({tag, "_req"},   32'(bus.bus_req), 32'h0);
    checkOutput({tag, "_we"},    32'(bus.bus_we), 32'h0);
    checkOutput({tag, "_addr"},  bus.bus_addr, 32'h0);
    checkOutput({tag, "_be"},    32'(bus.bus_be), 32'h0);
    checkOutput({tag, "_wdata"}, bus.bus_wdata, 32'h0);
    checkOutput({tag, "_rdata"}, lsu_rdata, 32'h0);
    checkOutput({tag, "_mis"},   32'(misaligned), 32'h0);
    checkOutput({tag, "_err"},   32'(bus_err), 32'h0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] simulation watchdog expired");
  end

  initial begin
    rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; mem_size = MEM_WORD;
    mem_usign_load = 1'b0; addr = '0; wdata = '0;
    bus.bus_gnt = 1'b0; bus.bus_rvalid = 1'b0; bus.bus_rdata = '0;
    step(); step(); #1;
    checkQuiet("reset");
    step(); rst = 1'b0;

    // SW 0x104 <- DEADBEEF, grant in first REQ cycle
    applyStimulus(1'b0, 1'b1, MEM_WORD, 1'b0, 32'h104, 32'hDEADBEEF);
    checkOutput("sw_c1_stall", 32'(lsu_stall), 32'h1);
    checkOutput("sw_c1_req", 32'(bus.bus_req), 32'h0);
    step(); idleInputs(); bus.bus_gnt = 1'b1; #1;
    checkOutput("sw_c2_req", 32'(bus.bus_req), 32'h1);
    checkOutput("sw_c2_stall", 32'(lsu_stall), 32'h1);
    checkOutput("sw_addr", bus.bus_addr, 32'h104);
    checkOutput("sw_be", 32'(bus.bus_be), 32'hF);
    checkOutput("sw_wdata", bus.bus_wdata, 32'hDEADBEEF);
    checkOutput("sw_we", 32'(bus.bus_we), 32'h1);
    step(); bus.bus_gnt = 1'b0; #1;
    checkOutput("sw_c3_done", 32'(lsu_done), 32'h1);
    checkOutput("sw_c3_stall", 32'(lsu_stall), 32'h0);
    checkOutput("sw_c3_req", 32'(bus.bus_req), 32'h0);
    checkOutput("sw_c3_err", 32'(bus_err), 32'h0);
    step(); #1;
    checkOutput("sw_c4_done", 32'(lsu_done), 32'h0);

    // SB 0x203 <- A5
    applyStimulus(1'b0, 1'b1, MEM_BYTE, 1'b0, 32'h203, 32'h000000A5);
    step(); idleInputs(); bus.bus_gnt = 1'b1; #1;
    checkOutput("sb_addr", bus.bus_addr, 32'h200);
    checkOutput("sb_be", 32'(bus.bus_be), 32'h8);
    checkOutput("sb_wdata", bus.bus_wdata, 32'hA5A5A5A5);
    step(); bus.bus_gnt = 1'b0; #1;
    checkOutput("sb_done", 32'(lsu_done), 32'h1);
    step();

    // SH 0x106 <- 1234
    applyStimulus(1'b0, 1'b1, MEM_HALF, 1'b0, 32'h106, 32'hFFFF1234);
    step(); idleInputs(); bus.bus_gnt = 1'b1; #1;
    checkOutput("sh_addr", bus.bus_addr, 32'h104);
    checkOutput("sh_be", 32'(bus.bus_be), 32'hC);
    checkOutput("sh_wdata", bus.bus_wdata, 32'h12341234);
    step(); bus.bus_gnt = 1'b0; step();

    // LB / LBU 0x102, word 0x1280FF34, rvalid 2 cycles after grant; then LH 0x102
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 1'b0, (k == 2) ? MEM_HALF : MEM_BYTE, (k == 1), 32'h102, 32'h0);
      step(); idleInputs(); bus.bus_gnt = 1'b1; #1;
      checkOutput("ld_addr", bus.bus_addr, 32'h100);
      checkOutput("ld_be", 32'(bus.bus_be), 32'hF);
      checkOutput("ld_we", 32'(bus.bus_we), 32'h0);
      step(); bus.bus_gnt = 1'b0; #1;
      checkOutput("ld_wait_stall", 32'(lsu_stall), 32'h1);
      checkOutput("ld_wait_rdata", lsu_rdata, 32'h0);
      step(); bus.bus_rvalid = 1'b1;
      bus.bus_rdata = (k == 2) ? 32'h80011234 : 32'h1280FF34;
      step(); bus.bus_rvalid = 1'b0; bus.bus_rdata = 32'h0; #1;
      checkOutput("ld_done", 32'(lsu_done), 32'h1);
      checkOutput("ld_rdata", lsu_rdata, (k == 0) ? 32'hFFFFFF80 : (k == 1) ? 32'h00000080 : 32'hFFFF8001);
      step(); #1;
      checkOutput("ld_rdata_idle", lsu_rdata, 32'h0);
    end

    // Misaligned LH 0x101, LW 0x102; read+write together
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, (k == 2), (k == 0) ? MEM_HALF : MEM_WORD, 1'b0,
                    (k == 0) ? 32'h101 : (k == 1) ? 32'h102 : 32'h100, 32'h0);
      checkOutput("flt_c1_req", 32'(bus.bus_req), 32'h0);
      checkOutput("flt_c1_stall", 32'(lsu_stall), 32'h1);
      step(); idleInputs(); #1;
      checkOutput("flt_done", 32'(lsu_done), 32'h1);
      checkOutput("flt_mis", 32'(misaligned), (k == 2) ? 32'h0 : 32'h1);
      checkOutput("flt_err", 32'(bus_err), (k == 2) ? 32'h1 : 32'h0);
      checkOutput("flt_req", 32'(bus.bus_req), 32'h0);
      checkOutput("flt_stall", 32'(lsu_stall), 32'h0);
      checkOutput("flt_rdata", lsu_rdata, 32'h0);
      step();
    end

    // LW with grant never given: timeout after TIMEOUT_CYC=4 bus cycles
    applyStimulus(1'b1, 1'b0, MEM_WORD, 1'b0, 32'h300, 32'h0);
    reqSeen = 1'b0;
    for (int i = 0; i < 12 && !lsu_done; i++) begin
      step(); idleInputs(); #1;
      if (bus.bus_req) reqSeen = 1'b1;
    end
    checkOutput("to_req_seen", 32'(reqSeen), 32'h1);
    checkOutput("to_done", 32'(lsu_done), 32'h1);
    checkOutput("to_err", 32'(bus_err), 32'h1);
    checkOutput("to_req_drop", 32'(bus.bus_req), 32'h0);
    checkOutput("to_rdata", lsu_rdata, 32'h0);
    step();

    // Reset while in WAIT, then a stray rvalid
    applyStimulus(1'b1, 1'b0, MEM_WORD, 1'b0, 32'h400, 32'h0);
    step(); idleInputs(); bus.bus_gnt = 1'b1;
    step(); bus.bus_gnt = 1'b0; #1;
    checkOutput("rw_in_wait", 32'(lsu_stall), 32'h1);
    rst = 1'b1;
    step(); rst = 1'b0; bus.bus_rvalid = 1'b1; bus.bus_rdata = 32'hCAFEF00D; #1;
    checkQuiet("rw_after_rst");
    step(); bus.bus_rvalid = 1'b0; #1;
    checkQuiet("rw_after_rvalid");

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
